// File: rtl/dram_arb_pkg.sv
// Shared types for the DRAM port arbiter.
// FSM states, owner tags and the instruction-fetch read control code.
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2,
        RESP     = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    localparam logic [2:0] IF_RD_CTRL = 3'b101;

endpackage

// File: rtl/dram_arb_priority.sv
// Grant decision for the shared DRAM port.
// MEM wins ties unless IF has lost too many arbitrations in a row.
module dram_arb_priority (
    input  logic i_if_req,
    input  logic i_mem_req,
    input  logic i_starved,
    output logic o_grant_if,
    output logic o_grant_mem
);

    // IF wins alone, or on a tie once it has been starved long enough
    always_comb begin
        o_grant_if  = i_if_req && (!i_mem_req || i_starved);
        o_grant_mem = i_mem_req && !(i_if_req && i_starved);
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Two-requester (IF / MEM) arbiter for the single DRAM port.
// One outstanding access; registered request, ack wait, one-cycle response.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic [2:0]  if_rd_ctrl,
    output logic [63:0] if_rdata,
    output logic        if_valid,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [63:0] mem_addr,
    input  logic [2:0]  mem_rd_ctrl,
    input  logic [1:0]  mem_wr_ctrl,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_valid,
    output logic        dram_req,
    output logic        dram_we,
    output logic [63:0] dram_addr,
    output logic [2:0]  dram_rd_ctrl,
    output logic [1:0]  dram_wr_ctrl,
    output logic [63:0] dram_wdata,
    input  logic [63:0] dram_rdata,
    input  logic        dram_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    arb_state_t  r_state;
    arb_state_t  w_next;
    arb_owner_t  w_owner;
    logic [SW-1:0] r_starve;
    logic [TW-1:0] r_tcnt;

    logic        r_dram_req;
    logic        r_dram_we;
    logic [63:0] r_dram_addr;
    logic [2:0]  r_dram_rd_ctrl;
    logic [1:0]  r_dram_wr_ctrl;
    logic [63:0] r_dram_wdata;
    logic [63:0] r_if_rdata;
    logic [63:0] r_mem_rdata;
    logic        r_if_valid;
    logic        r_mem_valid;
    logic        r_bus_err;

    logic w_starved;
    logic w_gnt_if;
    logic w_gnt_mem;
    logic w_take_if;
    logic w_take_mem;
    logic w_done;
    logic w_abort;
    logic w_busy;
    logic w_to_hit;

    assign w_starved = (r_starve == SW'(STARVE_LIMIT));
    assign w_busy    = (r_state == BUSY_IF) || (r_state == BUSY_MEM);
    assign w_to_hit  = (r_tcnt == TW'(TIMEOUT_CYC - 1));
    assign w_owner   = (r_state == BUSY_IF) ? OWN_IF : OWN_MEM;

    dram_arb_priority u_prio (
        .i_if_req    (if_req),
        .i_mem_req   (mem_req),
        .i_starved   (w_starved),
        .o_grant_if  (w_gnt_if),
        .o_grant_mem (w_gnt_mem)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state plus grant / completion strobes
    always_comb begin
        w_next     = r_state;
        w_take_if  = 1'b0;
        w_take_mem = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_gnt_mem) begin
                    w_take_mem = 1'b1;
                    w_next     = BUSY_MEM;
                end else if (w_gnt_if) begin
                    w_take_if = 1'b1;
                    w_next    = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (dram_ack) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end else if (w_to_hit) begin
                    w_abort = 1'b1;
                    w_next  = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Starvation and BUSY timeout counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
            r_tcnt   <= '0;
        end else begin
            if (w_take_if)
                r_starve <= '0;
            else if (w_take_mem && if_req)
                r_starve <= r_starve + SW'(1);
            r_tcnt <= w_busy ? r_tcnt + TW'(1) : '0;
        end
    end

    // DRAM port registers, response capture and completion pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dram_req     <= 1'b0;
            r_dram_we      <= 1'b0;
            r_dram_addr    <= '0;
            r_dram_rd_ctrl <= '0;
            r_dram_wr_ctrl <= '0;
            r_dram_wdata   <= '0;
            r_if_rdata     <= '0;
            r_mem_rdata    <= '0;
            r_if_valid     <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            r_if_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_bus_err   <= 1'b0;
            if (w_take_mem) begin
                r_dram_req     <= 1'b1;
                r_dram_we      <= mem_we;
                r_dram_addr    <= mem_addr;
                r_dram_rd_ctrl <= mem_rd_ctrl;
                r_dram_wr_ctrl <= mem_wr_ctrl;
                r_dram_wdata   <= mem_wdata;
            end
            if (w_take_if) begin
                r_dram_req     <= 1'b1;
                r_dram_we      <= 1'b0;
                r_dram_addr    <= if_addr;
                r_dram_rd_ctrl <= if_rd_ctrl;
                r_dram_wr_ctrl <= '0;
                r_dram_wdata   <= '0;
            end
            if (w_done || w_abort) begin
                r_dram_req <= 1'b0;
                r_bus_err  <= w_abort;
                if (w_owner == OWN_IF) begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= w_abort ? 64'd0 : dram_rdata;
                end else begin
                    r_mem_valid <= 1'b1;
                    r_mem_rdata <= w_abort ? 64'd0 : dram_rdata;
                end
            end
        end
    end

    assign dram_req     = r_dram_req;
    assign dram_we      = r_dram_we;
    assign dram_addr    = r_dram_addr;
    assign dram_rd_ctrl = r_dram_rd_ctrl;
    assign dram_wr_ctrl = r_dram_wr_ctrl;
    assign dram_wdata   = r_dram_wdata;
    assign if_rdata     = r_if_rdata;
    assign if_valid     = r_if_valid;
    assign mem_rdata    = r_mem_rdata;
    assign mem_valid    = r_mem_valid;
    assign bus_err      = r_bus_err;
    assign stall_if     = if_req && !r_if_valid;
    assign stall_mem    = mem_req && !r_mem_valid;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model.
module tb_dram_port_arbiter;
    import dram_arb_pkg::*;

    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic [2:0]  if_rd_ctrl;
    logic [63:0] if_rdata;
    logic        if_valid;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [2:0]  mem_rd_ctrl;
    logic [1:0]  mem_wr_ctrl;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_valid;
    logic        dram_req;
    logic        dram_we;
    logic [63:0] dram_addr;
    logic [2:0]  dram_rd_ctrl;
    logic [1:0]  dram_wr_ctrl;
    logic [63:0] dram_wdata;
    logic [63:0] dram_rdata;
    logic        dram_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dram_port_arbiter #(
        .STARVE_LIMIT (SL),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rd_ctrl   (if_rd_ctrl),
        .if_rdata     (if_rdata),
        .if_valid     (if_valid),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_rd_ctrl  (mem_rd_ctrl),
        .mem_wr_ctrl  (mem_wr_ctrl),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_valid    (mem_valid),
        .dram_req     (dram_req),
        .dram_we      (dram_we),
        .dram_addr    (dram_addr),
        .dram_rd_ctrl (dram_rd_ctrl),
        .dram_wr_ctrl (dram_wr_ctrl),
        .dram_wdata   (dram_wdata),
        .dram_rdata   (dram_rdata),
        .dram_ack     (dram_ack),
        .stall_if     (stall_if),
        .stall_mem    (stall_mem),
        .bus_err      (bus_err)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: one access in flight, described by who owns it and how
    // many cycles it has been waiting on the DRAM.
    bit          m_busy, m_resp, m_own_if;
    int          m_age, m_loss;
    logic        e_req, e_we, e_ifv, e_memv, e_err;
    logic [63:0] e_addr, e_wd, e_ifd, e_memd;
    logic [2:0]  e_rd;
    logic [1:0]  e_wr;
    wire m_if_wins = if_req && (!mem_req || m_loss >= SL);

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 0; m_resp <= 0; m_own_if <= 0;
            m_age <= 0; m_loss <= 0;
            e_req <= 0; e_we <= 0; e_addr <= 0; e_rd <= 0;
            e_wr <= 0; e_wd <= 0; e_ifv <= 0; e_memv <= 0;
            e_err <= 0; e_ifd <= 0; e_memd <= 0;
        end else begin
            e_ifv <= 0; e_memv <= 0; e_err <= 0;
            if (m_busy) begin
                if (dram_ack || m_age == TO) begin
                    m_busy <= 0; m_resp <= 1; e_req <= 0;
                    e_err <= !dram_ack;
                    if (m_own_if) begin
                        e_ifv <= 1;
                        e_ifd <= dram_ack ? dram_rdata : 64'd0;
                    end else begin
                        e_memv <= 1;
                        e_memd <= dram_ack ? dram_rdata : 64'd0;
                    end
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (m_resp) begin
                m_resp <= 0;
            end else if (if_req || mem_req) begin
                m_busy <= 1; m_age <= 1; e_req <= 1;
                m_own_if <= m_if_wins;
                if (m_if_wins) begin
                    m_loss <= 0;
                    e_we <= 0; e_addr <= if_addr; e_rd <= if_rd_ctrl;
                    e_wr <= 0; e_wd <= 0;
                end else begin
                    if (if_req) m_loss <= m_loss + 1;
                    e_we <= mem_we; e_addr <= mem_addr;
                    e_rd <= mem_rd_ctrl; e_wr <= mem_wr_ctrl;
                    e_wd <= mem_wdata;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dram_req", dram_req, e_req);
            chk("if_valid", if_valid, e_ifv);
            chk("mem_valid", mem_valid, e_memv);
            chk("bus_err", bus_err, e_err);
            chk("if_rdata", if_rdata, e_ifd);
            chk("mem_rdata", mem_rdata, e_memd);
            chk("stall_if", stall_if, if_req && !e_ifv);
            chk("stall_mem", stall_mem, mem_req && !e_memv);
            if (e_req) begin
                chk("dram_we", dram_we, e_we);
                chk("dram_addr", dram_addr, e_addr);
                chk("dram_rd_ctrl", dram_rd_ctrl, e_rd);
                chk("dram_wr_ctrl", dram_wr_ctrl, e_wr);
                chk("dram_wdata", dram_wdata, e_wd);
            end
        end
    end

    initial begin
        bit deaf;
        bit prev_req;
        int n;
        reset = 1; if_req = 0; if_addr = 0; if_rd_ctrl = IF_RD_CTRL;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_rd_ctrl = 0;
        mem_wr_ctrl = 0; mem_wdata = 0; dram_rdata = 0; dram_ack = 0;
        repeat (3) tick();
        reset = 0;
        chk_en = 1'b1;
        chk("rst dram_req", dram_req, 1'b0);
        chk("rst dram_addr", dram_addr, 64'd0);
        chk("rst if_valid", if_valid, 1'b0);

        // IF-only read, ack on the second BUSY cycle
        if_req = 1; if_addr = 64'h8000_0000;
        tick();
        chk("t1 dram_req", dram_req, 1'b1);
        chk("t1 dram_addr", dram_addr, 64'h8000_0000);
        chk("t1 dram_rd_ctrl", dram_rd_ctrl, 3'b101);
        chk("t1 dram_we", dram_we, 1'b0);
        tick();
        dram_ack = 1; dram_rdata = 64'h13;
        tick();
        dram_ack = 0;
        chk("t1 if_valid", if_valid, 1'b1);
        chk("t1 if_rdata", if_rdata, 64'h13);
        chk("t1 stall_if", stall_if, 1'b0);
        if_req = 0;
        tick();
        chk("t1 if_valid off", if_valid, 1'b0);
        chk("t1 rdata hold", if_rdata, 64'h13);

        // Simultaneous requests: MEM first, then IF
        if_req = 1; if_addr = 64'h8000_0004;
        mem_req = 1; mem_we = 0; mem_addr = 64'h8000_0100;
        mem_rd_ctrl = 3'b011;
        tick();
        chk("t2 mem first", dram_addr, 64'h8000_0100);
        chk("t2 stall_if", stall_if, 1'b1);
        dram_ack = 1; dram_rdata = 64'h1111;
        tick();
        dram_ack = 0;
        chk("t2 mem_valid", mem_valid, 1'b1);
        chk("t2 stall_if resp", stall_if, 1'b1);
        mem_req = 0;
        tick();
        chk("t2 idle", dram_req, 1'b0);
        tick();
        chk("t2 if second", dram_addr, 64'h8000_0004);
        dram_ack = 1;
        tick();
        dram_ack = 0;
        if_req = 0;
        tick();

        // Starvation: IF wins the 5th arbitration, then MEM wins again
        if_req = 1; if_addr = 64'h8000_0008;
        mem_req = 1; mem_addr = 64'h8000_1000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 5)
                chk("t3 if forced", dram_addr, 64'h8000_0008);
            else
                chk("t3 mem wins", dram_addr, mem_addr);
            dram_ack = 1;
            tick();
            dram_ack = 0;
            mem_addr = mem_addr + 64'h8;
            if (k == 5) if_addr = 64'h8000_000C;
            tick();
        end
        mem_req = 0;
        tick();
        chk("t3 if after", dram_addr, 64'h8000_000C);
        dram_ack = 1;
        tick();
        dram_ack = 0;
        if_req = 0;
        tick();

        // Store with fields held across a slow ack
        mem_req = 1; mem_we = 1; mem_addr = 64'h8000_0200;
        mem_wdata = 64'hDEAD_BEEF; mem_wr_ctrl = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4 we", dram_we, 1'b1);
            chk("t4 addr", dram_addr, 64'h8000_0200);
            chk("t4 wdata", dram_wdata, 64'hDEAD_BEEF);
            chk("t4 wr_ctrl", dram_wr_ctrl, 2'b11);
        end
        dram_ack = 1; dram_rdata = 64'h55;
        tick();
        dram_ack = 0;
        chk("t4 mem_valid", mem_valid, 1'b1);
        mem_req = 0; mem_we = 0; mem_wr_ctrl = 0;
        tick();
        chk("t4 mem_valid pulse", mem_valid, 1'b0);

        // Timeout with no ack
        if_req = 1; if_addr = 64'h8000_0300;
        tick();
        n = 0;
        while (dram_req && n < 20) begin
            n++;
            tick();
        end
        chk("t5 busy cycles", n, TO);
        chk("t5 bus_err", bus_err, 1'b1);
        chk("t5 if_valid", if_valid, 1'b1);
        chk("t5 if_rdata", if_rdata, 64'd0);
        if_req = 0;
        tick();

        // Reset during BUSY_MEM, then a late ack
        mem_req = 1; mem_addr = 64'h8000_0400;
        tick();
        tick();
        reset = 1;
        tick();
        chk("t6 req drop", dram_req, 1'b0);
        chk("t6 no valid", mem_valid, 1'b0);
        reset = 0; mem_req = 0; dram_ack = 1;
        tick();
        chk("t6 late ack", mem_valid, 1'b0);
        dram_ack = 0;
        tick();
        chk("t6 still idle", dram_req, 1'b0);

        // Random traffic
        deaf = 0;
        prev_req = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (dram_req && !prev_req) deaf = ($urandom_range(0, 5) == 0);
            prev_req = dram_req;
            if (dram_req)
                dram_ack = !deaf && ($urandom_range(0, 2) == 0);
            else
                dram_ack = ($urandom_range(0, 7) == 0);
            dram_rdata = {$urandom, $urandom};
            if (if_valid || (!if_req && $urandom_range(0, 2) == 0)) begin
                if_req = if_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                if_addr = {32'h0, $urandom};
            end
            if (mem_valid || (!mem_req && $urandom_range(0, 2) == 0)) begin
                mem_req = mem_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_we = 1'($urandom_range(0, 1));
                mem_addr = {32'h0, $urandom};
                mem_rd_ctrl = 3'($urandom_range(0, 7));
                mem_wr_ctrl = 2'($urandom_range(0, 3));
                mem_wdata = {$urandom, $urandom};
            end
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
Shares the single DRAM port between two requesters: the instruction-fetch channel, which fetches from DRAM when the PC is at or above DRAM_BASE_ADDR, and the MEM-stage load/store unit. It arbitrates with MEM priority and IF anti-starvation, registers the winning request onto the DRAM port, and waits for the DRAM acknowledge. It returns read data and a completion pulse to the owner and generates per-requester stall signals for the pipeline. It sits between the pipeline front/back ends and the DRAM model.

Parameters:
STARVE_LIMIT, 4, consecutive arbitrations IF may lose to MEM before IF is forced to win.
TIMEOUT_CYC, 255, cycles in BUSY without dram_ack before the access is aborted with error.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  IF channel requests a DRAM read; held until if_valid
if_addr  in  64  IF read address
if_rd_ctrl  in  3  IF read control (3'b101 for instruction word)
if_rdata  out  64  IF read data, meaningful while if_valid
if_valid  out  1  one-cycle IF completion pulse
mem_req  in  1  MEM stage request; held until mem_valid
mem_we  in  1  1 = store, 0 = load
mem_addr  in  64  MEM address
mem_rd_ctrl  in  3  load control
mem_wr_ctrl  in  2  store size control
mem_wdata  in  64  store data
mem_rdata  out  64  load data, meaningful while mem_valid
mem_valid  out  1  one-cycle MEM completion pulse
dram_req  out  1  access request to DRAM, held until dram_ack
dram_we  out  1  write enable
dram_addr  out  64  DRAM address
dram_rd_ctrl  out  3  DRAM read control
dram_wr_ctrl  out  2  DRAM write control
dram_wdata  out  64  DRAM write data
dram_rdata  in  64  DRAM read data, valid with dram_ack
dram_ack  in  1  DRAM access complete
stall_if  out  1  combinational: if_req && !if_valid
stall_mem  out  1  combinational: mem_req && !mem_valid
bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset and clocking
  - Single clock domain: clk.
  - reset is synchronous, active-high.
  - Reset values: all registered outputs 0, dram_* 0, state IDLE, starve counter 0, timeout counter 0.
- States: IDLE, BUSY_IF, BUSY_MEM, RESP.
- IDLE arbitration
  - mem_req only: MEM wins.
  - if_req only: IF wins.
  - Both asserted: MEM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - starve_cnt increments on each arbitration IF loses while requesting.
  - starve_cnt clears whenever IF is granted.
  - No requests: stay in IDLE.
- Grant
  - On grant in cycle N, the owner's addr/ctrl/wdata are registered onto the dram_* outputs.
  - dram_req is high from cycle N+1.
  - dram_we is 0 for IF grants.
- BUSY
  - dram_req and all dram_* outputs are held stable until dram_ack is sampled high.
  - On ack: capture dram_rdata into the owner's rdata register, drop dram_req, go to RESP.
  - The owner's valid is 1 in the RESP cycle.
  - Minimum latency: request at N, ack at N+1, valid at N+2.
- RESP
  - Exactly one cycle; no arbitration.
  - The requester must drop or replace its req before the next IDLE cycle.
  - Then go to IDLE.
- Data hold: if_rdata/mem_rdata hold their last captured value until the next completion for that requester.
- Timeout
  - Timeout counter runs in BUSY and clears on entering BUSY.
  - When it reaches TIMEOUT_CYC: drop dram_req, go to RESP with owner valid = 1, rdata = 0, bus_err = 1 for that cycle.
- Boundary cases
  - dram_ack while IDLE or RESP is ignored.
  - Requests change only while owner valid is 1 (held-request protocol).
  - Reset mid-access aborts immediately: dram_req drops the next edge and no valid is produced.
- No reordering: one outstanding DRAM access at a time.

Decomposition:
- Shared package (dram_arb_pkg):
  - state enum (IDLE, BUSY_IF, BUSY_MEM, RESP).
  - owner enum (OWN_IF, OWN_MEM).
  - rd_ctrl constant for instruction fetch (3'b101).
- Sub-module dram_arb_priority: combinational MEM-priority / starvation-override grant logic. Only the starve counter lives in the parent.

Test Plan:
- IF-only read:
  - Stimulus: if_req, if_addr = 0x8000_0000, ack after 2 cycles with rdata = 0x0000_0013.
  - Response: dram_addr = 0x8000_0000, dram_rd_ctrl = 3'b101, if_valid pulse with if_rdata = 0x13, stall_if low after the pulse.
- Simultaneous requests:
  - Stimulus: if_req and mem_req (load 0x8000_0100) same cycle.
  - Response: MEM served first, IF granted in the first IDLE after RESP, stall_if high throughout MEM's access.
- Starvation:
  - Stimulus: mem_req continuously re-asserted, if_req held, STARVE_LIMIT = 4.
  - Response: IF granted on the 5th arbitration; starve counter then 0.
- Store:
  - Stimulus: mem_we = 1, mem_addr = 0x8000_0200, mem_wdata = 0xDEAD_BEEF, mem_wr_ctrl = 2'b11.
  - Response: dram_we = 1 with matching fields held until ack, mem_valid one cycle.
- Timeout:
  - Stimulus: TIMEOUT_CYC = 8, no ack.
  - Response: dram_req drops after 8 BUSY cycles, bus_err and owner valid pulse together, rdata = 0.
- Reset mid-access:
  - Stimulus: assert reset while in BUSY_MEM, then a late dram_ack.
  - Response: dram_req = 0 the next cycle, no mem_valid, late ack ignored.
